// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// frame geometry and the even-parity helper.
package uart_pkg;

    localparam int DATA_BITS          = 8;
    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Even-parity bit for a data byte: 1 when the byte holds an odd number of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator for uart_rx: divides clk by CLKS_PER_TICK while
// enabled and emits a one-cycle tick. The clear input re-phases the divider
// so that tick timing is measured from the detected start edge.
module uart_rx_tick #(
    parameter int CLKS_PER_TICK = 54
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W   = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_TICK - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = en && !clr && (cnt_q == CNT_MAX);

    // Next divider count: restart on clear, wrap after the tick, hold while disabled.
    always_comb begin
        // NOTE: the default assignment comes first so every path assigns cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled (by default) recovery of 8N1 frames, or
// 8E1 frames when UART_RX_PARITY_EN is defined. Bytes are presented on a
// valid/ready register with parity/framing flags; a frame completing while
// the register is still occupied is dropped and flagged with an overrun pulse.
// A line held low after a bad stop bit is parked in BREAK until it returns high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = 54,
    parameter int OVERSAMPLE    = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int               SUB_W    = $clog2(OVERSAMPLE);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
    localparam int               BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    // Input synchroniser
    logic rx_meta_q, rx_s_q;

    // Receive FSM and datapath
    rx_state_e            state_q, state_d;
    logic [SUB_W-1:0]     sub_q, sub_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tick, sample, start_entry;
    logic                 deliver, stop_bad;

    // Output register
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_err_q, par_err_d;
    logic                 parity_err_q, parity_err_d;
`endif

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    assign start_entry = (state_q == ST_IDLE) && !rx_s_q;

    uart_rx_tick #(
        .CLKS_PER_TICK (CLKS_PER_TICK)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != ST_IDLE),
        .clr   (start_entry),
        .tick  (tick)
    );

    assign sample = tick && (sub_q == SUB_MID);

    // Next-state logic: sub-bit timing, bit sequencing and shift register.
    always_comb begin
        state_d   = state_q;
        sub_d     = sub_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        deliver   = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        if (tick) begin
            sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (!rx_s_q) begin
                    state_d = ST_START;
                    sub_d   = '0;
                end
            end
            ST_START: begin
                if (sample) begin
                    if (rx_s_q) begin
                        state_d = ST_IDLE;          // glitch, not a start bit
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shreg_d   = {rx_s_q, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (sample) begin
                    par_err_d = (rx_s_q != even_parity(shreg_q));
                    state_d   = ST_STOP;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_STOP: begin
                if (sample) begin
                    deliver  = 1'b1;
                    stop_bad = !rx_s_q;
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    state_d  = rx_s_q ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Receive FSM, counters and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shift register is reset along with the control state so an aborted frame leaves no residue.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sub_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sub_q     <= sub_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    // Output register: load when free (or being drained this cycle), else flag overrun.
    always_comb begin
        data_out_d   = data_out_q;
        rx_valid_d   = rx_valid_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
`endif
        if (deliver) begin
            if (!rx_valid_q || rd_ready) begin
                data_out_d   = shreg_q;
                frame_err_d  = stop_bad;
                rx_valid_d   = 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_d = par_err_q;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rd_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // Output register flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q   <= '0;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            data_out_q   <= data_out_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign data_out  = data_out_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Frames are driven serially at the exact
// bit period; expected bytes/flags come from a frame-level model (even parity
// via population count, framing error from the stop bit) and are compared
// against everything the monitor sees accepted on the valid/ready port.
module tb_uart_rx;

    localparam int CPT        = 8;
    localparam int OS         = 16;
    localparam int BIT_CYC    = CPT * OS;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON  = 1'b1;
`else
    localparam bit PARITY_ON  = 1'b0;
`endif
    localparam int FRAME_BITS = PARITY_ON ? 11 : 10;
    localparam int FRAME_CYC  = FRAME_BITS * BIT_CYC;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rd_ready;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    entry_t obs_q[$];
    entry_t exp_q[$];
    int     ovr_cnt    = 0;
    int     rise_cnt   = 0;
    int     last_rise  = 0;
    int     run        = 0;
    int     max_run    = 0;
    logic   prev_valid = 1'b0;

    uart_rx #(
        .CLKS_PER_TICK (CPT),
        .OVERSAMPLE    (OS)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_ready   (rd_ready),
        .data_out   (data_out),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor on the falling edge, away from the edge where inputs change.
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rise_cnt  = rise_cnt + 1;
            last_rise = cyc;
        end
        run = rx_valid ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (rx_valid && rd_ready) obs_q.push_back({data_out, parity_err, frame_err});
        if (overrun) ovr_cnt = ovr_cnt + 1;
        prev_valid = rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic odd_ones(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    // Frame-level reference: what the receiver must present for a frame sent with
    // data d, parity bit p and stop bit s.
    function automatic entry_t model(input logic [7:0] d, input logic p, input logic s);
        entry_t e;
        e.data = d;
        e.pe   = PARITY_ON && (p != odd_ones(d));
        e.fe   = !s;
        return e;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        wait_cyc(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CYC);
        if (PARITY_ON) drive_bit(p, BIT_CYC);
        drive_bit(s, BIT_CYC);
    endtask

    task automatic compare_queues(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
            check($sformatf("%s_perr%0d", tag, i), obs_q[i].pe, exp_q[i].pe);
            check($sformatf("%s_ferr%0d", tag, i), obs_q[i].fe, exp_q[i].fe);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int     t0, nominal, diff, r0, o0;
        logic [7:0] d;
        logic       p, s;
        int         gap;

        rst_n    = 1'b0;
        rx       = 1'b1;
        rd_ready = 1'b1;
        wait_cyc(3);
        check("rst_data_out",   data_out,   8'h00);
        check("rst_rx_valid",   rx_valid,   1'b0);
        check("rst_parity_err", parity_err, 1'b0);
        check("rst_frame_err",  frame_err,  1'b0);
        check("rst_overrun",    overrun,    1'b0);
        rst_n = 1'b1;
        wait_cyc(10);

        // Clean byte with latency and one-cycle valid pulse.
        max_run = 0;
        r0 = rise_cnt;
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        exp_q.push_back(model(8'hA5, 1'b0, 1'b1));
        drive_bit(1'b1, BIT_CYC);
        compare_queues("clean");
        check("clean_rises", rise_cnt - r0, 1);
        check("clean_valid_width", max_run, 1);
        nominal = 3 + ((FRAME_BITS - 1) * OS + OS / 2) * CPT;
        diff    = last_rise - t0;
        check("clean_latency_in_window", (diff >= nominal - 2) && (diff <= nominal + 2), 1'b1);

        // Parity error: 0x01 with parity bit 0.
        send_frame(8'h01, 1'b0, 1'b1);
        exp_q.push_back(model(8'h01, 1'b0, 1'b1));
        drive_bit(1'b1, BIT_CYC);
        compare_queues("parity");

        // Framing error followed by a long break.
        r0 = rise_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        exp_q.push_back(model(8'h3C, 1'b0, 1'b0));
        drive_bit(1'b0, 3 * FRAME_CYC);
        drive_bit(1'b1, 2 * BIT_CYC);
        compare_queues("break");
        check("break_rises", rise_cnt - r0, 1);

        // Glitch shorter than half a bit, then a normal frame.
        r0 = rise_cnt;
        drive_bit(1'b0, 4 * CPT);
        drive_bit(1'b1, 2 * BIT_CYC);
        check("glitch_rises", rise_cnt - r0, 0);
        compare_queues("glitch");
        send_frame(8'hE7, odd_ones(8'hE7), 1'b1);
        exp_q.push_back(model(8'hE7, odd_ones(8'hE7), 1'b1));
        drive_bit(1'b1, BIT_CYC);
        compare_queues("after_glitch");

        // Back-pressure: two back-to-back frames, consumer stalled.
        rd_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, odd_ones(8'h11), 1'b1);
        send_frame(8'h22, odd_ones(8'h22), 1'b1);
        drive_bit(1'b1, BIT_CYC);
        check("bp_valid_held", rx_valid, 1'b1);
        check("bp_data_held", data_out, 8'h11);
        check("bp_flags_held", {parity_err, frame_err}, 2'b00);
        check("bp_overrun_pulses", ovr_cnt - o0, 1);
        rd_ready = 1'b1;
        exp_q.push_back(model(8'h11, odd_ones(8'h11), 1'b1));
        wait_cyc(1);
        check("bp_valid_cleared", rx_valid, 1'b0);
        check("bp_data_kept", data_out, 8'h11);
        wait_cyc(2);
        compare_queues("bp");

        // Reset during data bit 4 with a byte still held in the output register.
        rd_ready = 1'b0;
        send_frame(8'h77, odd_ones(8'h77), 1'b1);
        drive_bit(1'b1, BIT_CYC);
        check("pre_rst_valid", rx_valid, 1'b1);
        check("pre_rst_data", data_out, 8'h77);
        d = 8'hC3;
        drive_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CYC);
        drive_bit(d[4], BIT_CYC / 2);
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check("midrst_rx_valid",   rx_valid,   1'b0);
        check("midrst_data_out",   data_out,   8'h00);
        check("midrst_parity_err", parity_err, 1'b0);
        check("midrst_frame_err",  frame_err,  1'b0);
        check("midrst_overrun",    overrun,    1'b0);
        wait_cyc(5);
        rst_n = 1'b1;
        drive_bit(1'b1, BIT_CYC);
        rd_ready = 1'b1;
        o0 = ovr_cnt;
        send_frame(8'h5A, odd_ones(8'h5A), 1'b1);
        exp_q.push_back(model(8'h5A, odd_ones(8'h5A), 1'b1));
        drive_bit(1'b1, BIT_CYC);
        compare_queues("post_rst");
        check("post_rst_overrun", ovr_cnt - o0, 0);

        // Randomised frames: random data, occasional bad parity/stop, random gaps.
        o0 = ovr_cnt;
        for (int n = 0; n < 12; n++) begin
            d = 8'($urandom);
            p = odd_ones(d) ^ (PARITY_ON && ($urandom_range(0, 3) == 0));
            s = ($urandom_range(0, 5) != 0);
            send_frame(d, p, s);
            exp_q.push_back(model(d, p, s));
            gap = s ? $urandom_range(0, 2 * BIT_CYC) : $urandom_range(BIT_CYC / 2, 2 * BIT_CYC);
            drive_bit(1'b1, gap);
        end
        drive_bit(1'b1, 2 * BIT_CYC);
        compare_queues("random");
        check("random_overrun", ovr_cnt - o0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
